arb_mux_n: RTL and testbench

ARB_MUX_N -- requirements
Module: arb_mux_n

---
 rtl/arb_mux_n_if.sv | 27 ++
 rtl/arb_mux_n.sv | 124 ++++++++++++
 tb/tb_arb_mux_n.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux_n_if.sv
// Channel-side and output-side handshake bundle for arb_mux_n.
// The master modport drives the channels and consumes the output; the slave is the mux.
interface arb_mux_n_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned NCH   = 2,
  parameter int unsigned SELW  = $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_sel;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/arb_mux_n.sv
// N-channel mux into a one-entry output register, explicit select (mode 0) or arbitrated (mode 1).
// Define ARB_MUX_RR_EN for round-robin in mode 1; otherwise mode 1 is fixed lowest-index priority.
module arb_mux_n #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned NCH   = 2,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input logic        clk,
  input logic        rst,
  arb_mux_n_if.slave bus
);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic             load_ok;
  logic             grant_valid;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;
  logic             accept;

  assign load_ok = !out_valid_q || bus.out_ready;
  assign accept  = grant_valid && load_ok && !rst;

  always_comb begin : grant_logic
`ifdef ARB_MUX_RR_EN
    logic            hi_v, lo_v;
    logic [SELW-1:0] hi, lo;
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi   = '0;
    lo   = '0;
`endif
    grant       = '0;
    grant_valid = 1'b0;
    if (!bus.mode) begin
      // An out-of-range sel matches no channel, so it can never grant.
      for (int i = 0; i < int'(NCH); i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          grant       = SELW'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
`ifdef ARB_MUX_RR_EN
      // Descending scan leaves the lowest valid index above ptr in hi and the lowest at or
      // below ptr in lo; hi wins, lo is the wrapped search with ptr itself checked last.
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          if (SELW'(i) > ptr_q) begin
            hi   = SELW'(i);
            hi_v = 1'b1;
          end else begin
            lo   = SELW'(i);
            lo_v = 1'b1;
          end
        end
      end
      grant       = hi_v ? hi : lo;
      grant_valid = hi_v || lo_v;
`else
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          grant       = SELW'(i);
          grant_valid = 1'b1;
        end
      end
`endif
    end
  end

  always_comb begin : data_mux
    grant_data = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (grant == SELW'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : ready_decode
    bus.in_ready = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      bus.in_ready[i] = accept && (grant == SELW'(i));
    end
  end

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (accept) begin
      // Covers the simultaneous drain-and-load case as well, keeping one word per cycle.
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
      ptr_d       = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: directed vector table, random run against a queue-based model,
// and a 3-channel instance for the out-of-range select case.
module tb_arb_mux_n;
  localparam int unsigned W = 5;
  localparam int unsigned N = 4;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_mux_n_if #(.WIDTH(W), .NCH(N), .SELW(S)) bus ();
  arb_mux_n_if #(.WIDTH(W), .NCH(3), .SELW(2)) bus3 ();

  arb_mux_n #(.WIDTH(W), .NCH(N), .SELW(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  arb_mux_n #(.WIDTH(W), .NCH(3), .SELW(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         rst;
    bit         mode;
    logic [1:0] sel;
    logic [3:0] iv;
    bit         ordy;
    logic [3:0] ready;
    bit         vld;
    logic [1:0] osel;
  } row_t;

  typedef struct {
    logic [W-1:0] data;
    logic [S-1:0] sel;
  } word_t;

  // Output register modelled as a depth-1 queue; mptr is the last granted channel.
  word_t mq[$];
  int    mptr = N - 1;
  row_t  rows[$];
  logic [N*W-1:0] fixed_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] chan_data(input int c);
    return bus.in_data[c*W +: W];
  endfunction

  function automatic int model_grant();
    if (!bus.mode) begin
      if (int'(bus.sel) < int'(N) && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
`ifdef ARB_MUX_RR_EN
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (mptr + k) % int'(N);
      if (bus.in_valid[c]) return c;
    end
`else
    for (int c = 0; c < int'(N); c++) begin
      if (bus.in_valid[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    g = model_grant();
    if (rst || g < 0 || !(mq.size() == 0 || bus.out_ready)) return '0;
    return N'(1 << g);
  endfunction

  task automatic model_edge();
    int  g;
    bit  acc;
    g   = model_grant();
    acc = (model_ready() != '0);
    if (rst) begin
      mq.delete();
      mptr = N - 1;
    end else begin
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{data: chan_data(g), sel: S'(g)});
        mptr = g;
      end
    end
  endtask

  task automatic drive(input bit r, input bit m, input logic [1:0] s, input logic [3:0] iv,
                       input bit ordy);
    rst           = r;
    bus.mode      = m;
    bus.sel       = s;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
  endtask

  // One clock: in_ready checked before the edge, registered outputs #1 after it.
  task automatic tick(input bit use_row, input row_t r);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
    if (use_row) check("row_in_ready", 32'(bus.in_ready), 32'(r.ready));
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("out_data", 32'(bus.out_data), 32'(mq[0].data));
      check("out_sel", 32'(bus.out_sel), 32'(mq[0].sel));
    end
    if (use_row) begin
      check("row_out_valid", 32'(bus.out_valid), 32'(r.vld));
      if (r.rst) begin
        check("row_rst_data", 32'(bus.out_data), 32'd0);
        check("row_rst_sel", 32'(bus.out_sel), 32'd0);
      end else if (r.vld) begin
        check("row_out_sel", 32'(bus.out_sel), 32'(r.osel));
        check("row_out_data", 32'(bus.out_data), 32'(fixed_data[r.osel*W +: W]));
      end
    end
  endtask

  task automatic add(input bit r, input bit m, input logic [1:0] s, input logic [3:0] iv,
                     input bit ordy, input logic [3:0] rdy, input bit v, input logic [1:0] os);
    rows.push_back('{rst: r, mode: m, sel: s, iv: iv, ordy: ordy, ready: rdy, vld: v, osel: os});
  endtask

  initial begin
    row_t dummy;
    dummy = '{rst: 0, mode: 0, sel: 0, iv: 0, ordy: 0, ready: 0, vld: 0, osel: 0};
    fixed_data = {5'h1A, 5'h15, 5'h0C, 5'h03};

    // Reset, explicit select, out-of-range-ish select with no valid
    add(1, 0, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0);
    add(0, 0, 2'd2, 4'b0100, 1, 4'b0100, 1, 2'd2);
    add(0, 0, 2'd3, 4'b0111, 1, 4'b0000, 0, 2'd0);
    add(1, 1, 2'd0, 4'b1111, 1, 4'b0000, 0, 2'd0);
`ifdef ARB_MUX_RR_EN
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd1);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2);
    add(0, 1, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0);
    add(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3);
    add(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1);
    add(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3);
`else
    for (int i = 0; i < 6; i++) add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd0);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);
    add(0, 1, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1);
`endif
    // Reset while a word is held and stalled, then first arbitrated grant
    add(1, 1, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0);
    add(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0);

    bus.in_data   = fixed_data;
    bus3.in_data  = {5'h11, 5'h0E, 5'h07};
    bus3.in_valid = '0;
    bus3.mode     = 1'b0;
    bus3.sel      = '0;
    bus3.out_ready = 1'b1;

    foreach (rows[i]) begin
      drive(rows[i].rst, rows[i].mode, rows[i].sel, rows[i].iv, rows[i].ordy);
      tick(1, rows[i]);
    end

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      bus.in_data = (N*W)'($urandom);
      tick(0, dummy);
    end

    // Three-channel instance: sel=3 is out of range and must never grant
    drive(1, 0, 2'd0, 4'b0000, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 2'd0, 4'b0000, 1);
    bus3.sel      = 2'd3;
    bus3.in_valid = 3'b111;
    #1;
    check("n3_oor_ready", 32'(bus3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("n3_oor_valid", 32'(bus3.out_valid), 32'd0);
    bus3.sel = 2'd2;
    #1;
    check("n3_sel2_ready", 32'(bus3.in_ready), 32'b100);
    @(posedge clk);
    #1;
    check("n3_sel2_valid", 32'(bus3.out_valid), 32'd1);
    check("n3_sel2_sel", 32'(bus3.out_sel), 32'd2);
    check("n3_sel2_data", 32'(bus3.out_data), 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
